// File: rtl/load_store_ctrl_if.sv
// Bus bundle for load_store_ctrl: the control-unit request side, the
// 64-bit data-memory req/ack side, the load result and a state debug tap.
//
// Handshake rules:
//   start is a one-cycle strobe. It is taken only while busy = 0. Each
//   accepted start produces exactly one done pulse. fault, when set, is
//   asserted in the same cycle as done.
//   mem_req stays high until the cycle in which mem_ack = 1.
//   mem_addr, mem_we and mem_wdata stay stable for as long as mem_req is
//   high. mem_rdata is consumed only in the cycle where mem_ack = 1.
interface load_store_ctrl_if;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] rdata;
    logic        done;
    logic        fault;
    logic        busy;
    logic [1:0]  dbg_state;

    // The sequencer's view of the bundle.
    modport slave (
        input  start, is_store, funct3, addr, wdata, mem_rdata, mem_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, rdata, done, fault,
               busy, dbg_state
    );

    // The view of the control unit and the memory combined.
    modport master (
        output start, is_store, funct3, addr, wdata, mem_rdata, mem_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, rdata, done, fault,
               busy, dbg_state
    );
endinterface

// File: rtl/load_store_ctrl.sv
// load_store_ctrl: multi-cycle load/store sequencer for a 64-bit data memory.
//
// Loads read the containing doubleword, then pick out the addressed lane
// and sign- or zero-extend it. Sub-doubleword stores first read the
// doubleword, merge in the new bytes, and write the whole doubleword back.
// sd writes directly. A request with an illegal funct3 or a misaligned
// address goes straight to the completion state and raises fault. It never
// touches memory.
module load_store_ctrl (
    input  logic             clk,
    input  logic             reset,
    load_store_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Request captured on accept.
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;
    logic [63:0] r_wdata;
    logic        r_fault;

    // Registered memory-side and result outputs.
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic [63:0] r_rdata;

    logic        w_accept;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_fault;
    logic        w_direct_sd;
    logic [5:0]  w_shamt;
    logic [63:0] w_lane;
    logic [63:0] w_load_val;
    logic [63:0] w_size_mask;
    logic [63:0] w_mask;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_merged;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_direct_sd = bus.is_store && (bus.funct3[1:0] == 2'b11);
    // Byte offset inside the doubleword, expressed as a bit shift.
    assign w_shamt     = {r_off, 3'b000};

    // Decode illegal width codes and misaligned addresses from the live request.
    always_comb begin
        w_illegal = bus.is_store ? bus.funct3[2] : (bus.funct3 == 3'b111);
        case (bus.funct3[1:0])
            2'b01:   w_misaligned = bus.addr[0];
            2'b10:   w_misaligned = |bus.addr[1:0];
            2'b11:   w_misaligned = |bus.addr[2:0];
            default: w_misaligned = 1'b0;
        endcase
        w_fault = w_illegal | w_misaligned;
    end

    // Bring the addressed lane down to bit 0, then extend it to 64 bits by width and sign.
    always_comb begin
        w_lane = bus.mem_rdata >> w_shamt;
        case (r_funct3)
            3'b000:  w_load_val = {{56{w_lane[7]}},  w_lane[7:0]};
            3'b001:  w_load_val = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load_val = {{32{w_lane[31]}}, w_lane[31:0]};
            3'b100:  w_load_val = {56'd0, w_lane[7:0]};
            3'b101:  w_load_val = {48'd0, w_lane[15:0]};
            3'b110:  w_load_val = {32'd0, w_lane[31:0]};
            default: w_load_val = w_lane;
        endcase
    end

    // Replace the store's byte lanes in the doubleword that was read back.
    always_comb begin
        case (r_funct3[1:0])
            2'b00:   w_size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   w_size_mask = 64'h0000_0000_0000_FFFF;
            default: w_size_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        w_mask     = w_size_mask << w_shamt;
        w_wdata_sh = r_wdata << w_shamt;
        w_merged   = (bus.mem_rdata & ~w_mask) | (w_wdata_sh & w_mask);
    end

    // State register. Reset returns to IDLE at once, which drops mem_req without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_fault) begin
                        w_next = S_FIN;
                    end else if (w_direct_sd) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                if (bus.mem_ack) begin
                    w_next = r_is_store ? S_WR : S_FIN;
                end
            end
            S_WR: begin
                if (bus.mem_ack) begin
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Drive control outputs from the state. The data outputs come from registers.
    always_comb begin
        bus.mem_req   = (r_state == S_RD) || (r_state == S_WR);
        bus.mem_we    = (r_state == S_WR);
        bus.done      = (r_state == S_FIN);
        bus.fault     = (r_state == S_FIN) && r_fault;
        bus.busy      = (r_state != S_IDLE);
        bus.mem_addr  = r_mem_addr;
        bus.mem_wdata = r_mem_wdata;
        bus.rdata     = r_rdata;
        bus.dbg_state = r_state;
    end

    // Capture the request and the aligned address when start is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'd0;
            r_off      <= 3'd0;
            r_wdata    <= 64'd0;
            r_fault    <= 1'b0;
            r_mem_addr <= 64'd0;
        end else if (w_accept) begin
            r_is_store <= bus.is_store;
            r_funct3   <= bus.funct3;
            r_off      <= bus.addr[2:0];
            r_wdata    <= bus.wdata;
            r_fault    <= w_fault;
            r_mem_addr <= {bus.addr[63:3], 3'b000};
        end
    end

    // Write data: set directly for sd, otherwise set from the merged read on the RMW read ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_wdata <= 64'd0;
        end else if (w_accept && w_direct_sd && !w_fault) begin
            r_mem_wdata <= bus.wdata;
        end else if ((r_state == S_RD) && bus.mem_ack && r_is_store) begin
            r_mem_wdata <= w_merged;
        end
    end

    // Load result: updated only when a load's read is acked. It holds through stores and faults.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= 64'd0;
        end else if ((r_state == S_RD) && bus.mem_ack && !r_is_store) begin
            r_rdata <= w_load_val;
        end
    end
endmodule

// File: tb/tb_load_store_ctrl.sv
// Bench for load_store_ctrl. It includes a memory responder with a
// configurable number of wait states and a byte-addressed reference memory
// used to predict load results and written doublewords.
module tb_load_store_ctrl;
    logic clk = 1'b0;
    logic reset;

    load_store_ctrl_if bus ();

    load_store_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- scoreboard state ----------------
    logic [64:0]  exp_q[$];   // {fault, rdata} expected at each done
    logic [128:0] acc_q[$];   // {we, aligned addr, write data} expected per memory access
    logic [63:0]  model_rdata = 64'd0;
    int           cur_wait    = 0;

    logic [7:0]   ref_mem [logic [63:0]];  // reference: byte addressed
    logic [63:0]  dmem    [logic [63:0]];  // responder: doubleword addressed

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual=event expected=none", name);
    endtask

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5 ^ {a[2:0], a[36:32]};
    endfunction

    function automatic logic [7:0] ref_get(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [63:0] mem_read(input logic [63:0] al);
        logic [63:0] v;
        if (dmem.exists(al)) return dmem[al];
        v = 64'd0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = init_byte(al + 64'(i));
        return v;
    endfunction

    task automatic preload(input logic [63:0] al, input logic [63:0] dw);
        dmem[al] = dw;
        for (int i = 0; i < 8; i++) ref_mem[al + 64'(i)] = dw[8*i +: 8];
    endtask

    // ---------------- memory responder ----------------
    int wcnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            wcnt = 0;
            bus.mem_ack = 1'b0;
        end else if (bus.mem_req) begin
            if (acc_q.size() == 0) begin
                fail_event("unexpected_mem_req");
            end else begin
                check("acc_we", 64'(bus.mem_we), 64'(acc_q[0][128]));
                check("acc_addr", bus.mem_addr, acc_q[0][127:64]);
                if (acc_q[0][128]) check("acc_wdata", bus.mem_wdata, acc_q[0][63:0]);
            end
            if (wcnt < cur_wait) begin
                wcnt++;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = {$urandom, $urandom};
            end else begin
                wcnt = 0;
                bus.mem_ack = 1'b1;
                if (bus.mem_we) dmem[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata = mem_read(bus.mem_addr);
                if (acc_q.size() > 0) void'(acc_q.pop_front());
            end
        end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
        end
    end

    // ---------------- completion monitor ----------------
    always @(negedge clk) begin
        logic [64:0] e;
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                fail_event("unexpected_done");
            end else begin
                e = exp_q.pop_front();
                check("done_fault", 64'(bus.fault), 64'(e[64]));
                check("done_rdata", bus.rdata, e[63:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Predict the outcome from byte-level memory semantics, then drive start for one cycle.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output int exp_lat, output int exp_req);
        int          size;
        logic        illegal;
        logic        mis;
        logic [63:0] al;
        logic [63:0] val;
        logic [63:0] dw;
        size    = 1 << f3[1:0];
        illegal = st ? f3[2] : (f3 == 3'b111);
        mis     = (a & 64'(size - 1)) != 64'd0;
        al      = a & ~64'h7;
        if (illegal || mis) begin
            exp_q.push_back({1'b1, model_rdata});
            exp_lat = 1;
            exp_req = 0;
        end else if (!st) begin
            val = 64'd0;
            for (int i = 0; i < size; i++) val = val | (64'(ref_get(a + 64'(i))) << (8 * i));
            if (!f3[2] && size < 8 && val[8*size-1]) val = val | ((~64'd0) << (8 * size));
            model_rdata = val;
            exp_q.push_back({1'b0, val});
            acc_q.push_back({1'b0, al, 64'd0});
            exp_lat = 2 + cur_wait;
            exp_req = cur_wait + 1;
        end else begin
            for (int i = 0; i < size; i++) ref_mem[a + 64'(i)] = wd[8*i +: 8];
            dw = 64'd0;
            for (int i = 0; i < 8; i++) dw = dw | (64'(ref_get(al + 64'(i))) << (8 * i));
            if (size < 8) begin
                acc_q.push_back({1'b0, al, 64'd0});
                exp_lat = 3 + 2 * cur_wait;
                exp_req = 2 * cur_wait + 2;
            end else begin
                exp_lat = 2 + cur_wait;
                exp_req = cur_wait + 1;
            end
            acc_q.push_back({1'b1, al, dw});
            exp_q.push_back({1'b0, model_rdata});
        end
        bus.start    = 1'b1;
        bus.is_store = st;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.wdata    = wd;
    endtask

    // Run one operation to completion. While it is busy, drive ignored start strobes carrying junk.
    task automatic run_op(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int w);
        int el, er, lat, req;
        bit seen, busy_ok;
        cur_wait = w;
        issue(st, f3, a, wd, el, er);
        lat = 0; req = 0; seen = 0; busy_ok = 1;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            lat++;
            if (bus.mem_req) req++;
            if (!bus.busy) busy_ok = 0;
            if (bus.done) seen = 1;
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.is_store = 1'($urandom_range(0, 1));
            bus.funct3   = 3'($urandom_range(0, 7));
            bus.addr     = {$urandom, $urandom};
            bus.wdata    = {$urandom, $urandom};
        end
        check("done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        check("latency", 64'(lat), 64'(el));
        check("req_cycles", 64'(req), 64'(er));
        check("busy_span", 64'(busy_ok), 64'd1);
        check("idle_after_done", 64'(bus.busy), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int el, er;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] a;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.is_store = 1'b0;
        bus.funct3   = 3'd0;
        bus.addr     = 64'd0;
        bus.wdata    = 64'd0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_we", 64'(bus.mem_we), 64'd0);
        check("rst_mem_addr", bus.mem_addr, 64'd0);
        check("rst_mem_wdata", bus.mem_wdata, 64'd0);
        check("rst_rdata", bus.rdata, 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_fault", 64'(bus.fault), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // lw with a zero-wait ack
        preload(64'h100, 64'h8000_0001_FFFF_FFFE);
        run_op(1'b0, 3'b010, 64'h104, 64'd0, 0);
        check("lw_value", bus.rdata, 64'hFFFF_FFFF_8000_0001);

        // lbu at the top byte, three wait cycles
        preload(64'h0, 64'hAB00_0000_0000_0000);
        run_op(1'b0, 3'b100, 64'h7, 64'd0, 3);
        check("lbu_value", bus.rdata, 64'h0000_0000_0000_00AB);

        // sb into byte 3 of 0x10 (read-modify-write)
        preload(64'h10, 64'h1122_3344_5566_7788);
        run_op(1'b1, 3'b000, 64'h13, 64'hFFFF_FFFF_FFFF_FF55, 0);
        check("sb_rdata_kept", bus.rdata, 64'h0000_0000_0000_00AB);

        // sh with waits to exercise the merge at a nonzero offset
        run_op(1'b1, 3'b001, 64'h16, 64'h0000_0000_0000_BEEF, 2);
        check("sh_mem", dmem[64'h10], 64'hBEEF_3344_5566_7788);

        // sd: a single write, no read
        run_op(1'b1, 3'b011, 64'h20, 64'hDEAD_BEEF_CAFE_F00D, 0);

        // faults: misaligned lh, load funct3 111, store funct3 1xx, misaligned sd
        run_op(1'b0, 3'b001, 64'h101, 64'd0, 0);
        run_op(1'b0, 3'b111, 64'h100, 64'd0, 0);
        run_op(1'b1, 3'b100, 64'h100, 64'd0, 0);
        run_op(1'b1, 3'b011, 64'h104, 64'd0, 0);

        // reset while a read is waiting for ack
        cur_wait = 20;
        issue(1'b0, 3'b011, 64'h200, 64'd0, el, er);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_pending", 64'(bus.mem_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_rdata", bus.rdata, 64'd0);
        exp_q.delete();
        acc_q.delete();
        model_rdata = 64'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_op(1'b0, 3'b010, 64'h104, 64'd0, 1);

        // randomized mix
        for (int k = 0; k < 200; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 64'h100 + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) a[63:32] = 32'hFFFF_0000;
            if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            run_op(st, f3, a, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("acc_q_drained", 64'(acc_q.size()), 64'd0);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
